// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the data-memory controller slice.
package qu_common;

  localparam int MEM_DEPTH = 4096;
  localparam int DMEM_AW   = $clog2(MEM_DEPTH);

  typedef logic [DMEM_AW-1:0] dmem_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    READ_BUSY,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_ctrl_ram.sv
// Word-organised data RAM with byte write enables and a read-first
// synchronous read port.
// Read data passes through an output register followed by RD_LATENCY-1
// pipeline stages.
module dmem_ram #(
  parameter int MEM_DEPTH  = 4096,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic [3:0]                   we_i,
  input  logic [$clog2(MEM_DEPTH)-3:0] waddr_i,
  input  logic [31:0]                  wdata_i,
  input  logic                         re_i,
  input  logic [$clog2(MEM_DEPTH)-3:0] raddr_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem_q  [MEM_DEPTH/4];
  logic [31:0] pipe_q [RD_LATENCY];

  // Byte-lane writes; lanes without an enable keep their contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // The issue edge captures the old word (read-first); later stages only shift it along.
  always_ff @(posedge clk) begin
    if (re_i) begin
      pipe_q[0] <= mem_q[raddr_i];
    end
    for (int s = 1; s < RD_LATENCY; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign rdata_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller that sits downstream of retire.
// It aligns store byte lanes, drops stores that cross a word boundary,
// and sequences loads so each load returns one tagged, right-justified response.
module dmem_ctrl #(
  parameter int MEM_DEPTH  = 4096,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   wr_en_in,
  input  logic                         rd_en_in,
  input  logic [31:0]                  addr_in,
  input  logic [31:0]                  data_in,
  output logic                         valid_out,
  output logic [$clog2(MEM_DEPTH)-1:0] valid_addr_out,
  output logic [31:0]                  data_out,
  output logic                         misaligned_out
);

  import qu_common::*;

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] raddr_q, vaddr_q;
  logic [31:0]   data_q;
  logic          mis_q;

  logic          storeReq;
  logic [6:0]    wmask;
  logic          misaligned;
  logic [3:0]    ramWe;
  logic [31:0]   wdataShift;
  logic          issue;
  logic [31:0]   ramRdata;
  logic [31:0]   rdAligned;
  logic          unused_addr_hi;

  assign storeReq       = |wr_en_in;
  assign wmask          = {3'b000, wr_en_in} << addr_in[1:0];
  assign misaligned     = |wmask[6:4];
  assign ramWe          = (storeReq && !misaligned) ? wmask[3:0] : 4'b0000;
  assign wdataShift     = data_in << {addr_in[1:0], 3'b000};
  assign rdAligned      = ramRdata >> {raddr_q[1:0], 3'b000};
  assign unused_addr_hi = ^addr_in[31:AW];

  dmem_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .RD_LATENCY(RD_LATENCY)
  ) u_ram (
    .clk    (clk),
    .we_i   (ramWe),
    .waddr_i(addr_in[AW-1:2]),
    .wdata_i(wdataShift),
    .re_i   (issue),
    .raddr_i(addr_in[AW-1:2]),
    .rdata_o(ramRdata)
  );

  // Next-state logic: a store blocks issue in IDLE, requests are ignored while busy, RESP always ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_en_in && !storeReq) begin
          issue   = 1'b1;
          cnt_d   = CW'(RD_LATENCY - 1);
          state_d = (RD_LATENCY > 1) ? READ_BUSY : RESP;
        end
      end
      READ_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latency counter; reset abandons any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold the load tag and the last response, and register the misaligned-store pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q <= '0;
      vaddr_q <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (issue) begin
        raddr_q <= addr_in[AW-1:0];
      end
      if (state_q == RESP) begin
        vaddr_q <= raddr_q;
        data_q  <= rdAligned;
      end
      mis_q <= storeReq && misaligned;
    end
  end

  assign valid_out      = (state_q == RESP);
  assign valid_addr_out = valid_out ? raddr_q : vaddr_q;
  assign data_out       = valid_out ? rdAligned : data_q;
  assign misaligned_out = mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl.
// Instance A uses RD_LATENCY=1 and instance B uses RD_LATENCY=3.
// Stimulus pushes the expected responses; the monitors pop and compare them.
module tb_dmem_ctrl;
  import qu_common::*;

  typedef struct {
    dmem_addr_t  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  logic [3:0]  aWr, bWr;
  logic        aRd, bRd;
  logic [31:0] aAddr, bAddr, aData, bData;
  logic        aValid, bValid, aMis, bMis;
  dmem_addr_t  aVAddr, bVAddr;
  logic [31:0] aDout, bDout;

  exp_t qA[$];
  exp_t qB[$];
  int   qMis[$];

  dmem_ctrl #(.MEM_DEPTH(4096), .RD_LATENCY(1)) dutA (
    .clk(clk), .rst(rst), .wr_en_in(aWr), .rd_en_in(aRd), .addr_in(aAddr),
    .data_in(aData), .valid_out(aValid), .valid_addr_out(aVAddr),
    .data_out(aDout), .misaligned_out(aMis)
  );

  dmem_ctrl #(.MEM_DEPTH(4096), .RD_LATENCY(3)) dutB (
    .clk(clk), .rst(rst), .wr_en_in(bWr), .rd_en_in(bRd), .addr_in(bAddr),
    .data_in(bData), .valid_out(bValid), .valid_addr_out(bVAddr),
    .data_out(bDout), .misaligned_out(bMis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so the monitors can check response timing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic applyStimulus(input int w, input logic [3:0] wr, input logic rd,
                               input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (w == 0) begin
      aWr = wr; aRd = rd; aAddr = addr; aData = data;
    end else begin
      bWr = wr; bRd = rd; bAddr = addr; bData = data;
    end
  endtask

  task automatic pushExp(input int w, input dmem_addr_t addr, input logic [31:0] data, input int c);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = c;
    if (w == 0) qA.push_back(e);
    else        qB.push_back(e);
  endtask

  task automatic doStore(input int w, input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit mis);
    applyStimulus(w, wr, 1'b0, addr, data);
    if (mis) qMis.push_back(cyc + 1);
  endtask

  // Retire-style load: hold rd until the response cycle, then drop it.
  task automatic doLoad(input int w, input logic [31:0] addr, input dmem_addr_t expAddr,
                        input logic [31:0] expData);
    int lat;
    lat = (w == 0) ? 1 : 3;
    applyStimulus(w, 4'b0000, 1'b1, addr, 32'h0);
    pushExp(w, expAddr, expData, cyc + lat);
    repeat (lat - 1) applyStimulus(w, 4'b0000, 1'b1, addr, 32'h0);
    applyStimulus(w, 4'b0000, 1'b0, addr, 32'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " A valid"}, 32'(aValid), 32'h0);
    checkOutput({tag, " A vaddr"}, 32'(aVAddr), 32'h0);
    checkOutput({tag, " A data"},  aDout,       32'h0);
    checkOutput({tag, " A mis"},   32'(aMis),   32'h0);
    checkOutput({tag, " B valid"}, 32'(bValid), 32'h0);
    checkOutput({tag, " B vaddr"}, 32'(bVAddr), 32'h0);
    checkOutput({tag, " B data"},  bDout,       32'h0);
    checkOutput({tag, " B mis"},   32'(bMis),   32'h0);
  endtask

  // Response monitors: every valid or misaligned pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    int   mc;
    if (aValid === 1'b1) begin
      if (qA.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL A unexpected valid: addr 0x%03h data 0x%08h, expected none (cycle %0d)", aVAddr, aDout, cyc);
      end else begin
        e = qA.pop_front();
        checkOutput("A rsp addr",  32'(aVAddr), 32'(e.addr));
        checkOutput("A rsp data",  aDout,       e.data);
        checkOutput("A rsp cycle", 32'(cyc),    32'(e.cyc));
      end
    end
    if (bValid === 1'b1) begin
      if (qB.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL B unexpected valid: addr 0x%03h data 0x%08h, expected none (cycle %0d)", bVAddr, bDout, cyc);
      end else begin
        e = qB.pop_front();
        checkOutput("B rsp addr",  32'(bVAddr), 32'(e.addr));
        checkOutput("B rsp data",  bDout,       e.data);
        checkOutput("B rsp cycle", 32'(cyc),    32'(e.cyc));
      end
    end
    if (aMis === 1'b1) begin
      if (qMis.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL A unexpected misaligned: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        mc = qMis.pop_front();
        checkOutput("A misaligned cycle", 32'(cyc), 32'(mc));
      end
    end
    if (bMis === 1'b1) begin
      tests++; fails++;
      $display("[TB] FAIL B unexpected misaligned: got 1, expected 0 (cycle %0d)", cyc);
    end
  end

  // Directed sequence.
  initial begin
    rst = 1'b1;
    aWr = 4'b0; aRd = 1'b0; aAddr = 32'h0; aData = 32'h0;
    bWr = 4'b0; bRd = 1'b0; bAddr = 32'h0; bData = 32'h0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;

    // A: SW then a held load.
    doStore(0, 4'b1111, 32'h10, 32'hDEADBEEF, 1'b0);
    doLoad(0, 32'h10, 12'h010, 32'hDEADBEEF);

    // A: SB into lane 3 repeated, then right-justified reads and an address wrap.
    doStore(0, 4'b0001, 32'h13, 32'h000000AA, 1'b0);
    doStore(0, 4'b0001, 32'h13, 32'h000000AA, 1'b0);
    doLoad(0, 32'h13, 12'h013, 32'h000000AA);
    doLoad(0, 32'h10, 12'h010, 32'hAAADBEEF);
    doLoad(0, 32'h1010, 12'h010, 32'hAAADBEEF);

    // A: misaligned stores are dropped and pulse once each.
    doStore(0, 4'b1111, 32'h08, 32'h11223344, 1'b0);
    doStore(0, 4'b0011, 32'h0B, 32'h0000BEEF, 1'b1);
    doStore(0, 4'b1111, 32'h06, 32'hFFFFFFFF, 1'b1);
    doLoad(0, 32'h08, 12'h008, 32'h11223344);
    doStore(0, 4'b0011, 32'h0A, 32'h0000BEEF, 1'b0);
    doLoad(0, 32'h0A, 12'h00A, 32'h0000BEEF);
    doLoad(0, 32'h09, 12'h009, 32'h00BEEF33);

    // A: store and load together in IDLE, the store goes first and the load issues a cycle later.
    applyStimulus(0, 4'b0001, 1'b1, 32'h11, 32'h00000077);
    pushExp(0, 12'h011, 32'h00AAAD77, cyc + 2);
    applyStimulus(0, 4'b0000, 1'b1, 32'h11, 32'h0);
    applyStimulus(0, 4'b0000, 1'b0, 32'h11, 32'h0);

    // B: eight cycles of held rd give exactly two responses, four cycles apart.
    doStore(1, 4'b1111, 32'h20, 32'hA5A50F0F, 1'b0);
    applyStimulus(1, 4'b0000, 1'b1, 32'h20, 32'h0);
    pushExp(1, 12'h020, 32'hA5A50F0F, cyc + 3);
    pushExp(1, 12'h020, 32'hA5A50F0F, cyc + 7);
    repeat (7) applyStimulus(1, 4'b0000, 1'b1, 32'h20, 32'h0);
    applyStimulus(1, 4'b0000, 1'b0, 32'h20, 32'h0);

    // B: a store during READ_BUSY is not visible until the next load.
    doStore(1, 4'b1111, 32'h30, 32'hCAFEF00D, 1'b0);
    applyStimulus(1, 4'b0000, 1'b1, 32'h30, 32'h0);
    pushExp(1, 12'h030, 32'hCAFEF00D, cyc + 3);
    applyStimulus(1, 4'b1111, 1'b1, 32'h30, 32'h12345678);
    applyStimulus(1, 4'b0000, 1'b1, 32'h30, 32'h0);
    applyStimulus(1, 4'b0000, 1'b0, 32'h30, 32'h0);
    doLoad(1, 32'h30, 12'h030, 32'h12345678);

    // B: reset one cycle after issue kills the read but keeps memory.
    doStore(1, 4'b1111, 32'h40, 32'h55AA1234, 1'b0);
    applyStimulus(1, 4'b0000, 1'b1, 32'h40, 32'h0);
    applyStimulus(1, 4'b0000, 1'b0, 32'h40, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("mid-read reset");
    rst = 1'b0;
    repeat (5) applyStimulus(1, 4'b0000, 1'b0, 32'h0, 32'h0);
    doLoad(1, 32'h40, 12'h040, 32'h55AA1234);

    // Drain, then every expected event must have been consumed.
    repeat (6) @(negedge clk);
    checkOutput("A responses left",  32'(qA.size()),   32'h0);
    checkOutput("B responses left",  32'(qB.size()),   32'h0);
    checkOutput("misaligned left",   32'(qMis.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
